cas_sequencer: RTL

Column-command stage directly downstream of the ACT/PRE sequencer. It accepts activate-complete events (`act_rdy`, plus a row-hit flag and column address), enforces tRCD, tCCD and write-to-read turnaround, and issues one-cycle CAS (RD/WR) requests to the command driver. It then tracks read/write latency so it can pulse `data_rdy` to the data stage. It also produces `cas_idle` and `cas_rw`, which the ACT/PRE sequencer uses for precharge decisions.

---
 rtl/cas_sequencer_if.sv | 36 +++
 rtl/cas_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cas_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : cas_sequencer_if
//  Brief    : Request/command/data-flag bundle of the column-command stage.
//  Revision : 1.0  initial release
// ============================================================================
interface cas_sequencer_if #(
   parameter int BG_WIDTH = 2,
   parameter int BA_WIDTH = 2,
   parameter int CA_WIDTH = 10
);
   logic                                   act_rdy;
   logic                                   act_hit;
   logic                                   act_rw;
   logic [BG_WIDTH-1:0]                    act_bg;
   logic [BA_WIDTH-1:0]                    act_ba;
   logic [CA_WIDTH-1:0]                    act_col;
   logic                                   cas_rdy;
   logic [BG_WIDTH+BA_WIDTH+CA_WIDTH-1:0]  cas_reg;
   logic                                   cas_rw;
   logic                                   cas_idle;
   logic                                   data_rdy;
   logic                                   data_rw;
   logic                                   overflow;

   modport master (
      output act_rdy, act_hit, act_rw, act_bg, act_ba, act_col,
      input  cas_rdy, cas_reg, cas_rw, cas_idle, data_rdy, data_rw, overflow
   );

   modport slave (
      input  act_rdy, act_hit, act_rw, act_bg, act_ba, act_col,
      output cas_rdy, cas_reg, cas_rw, cas_idle, data_rdy, data_rw, overflow
   );
endinterface
`default_nettype wire

// File: rtl/cas_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cas_sequencer
//  Brief    : Queues activated requests, enforces tRCD/tCCD/tWTR, issues CAS
//             pulses and flags the start of each data burst after CL/CWL.
//  Revision : 1.0  initial release
// ============================================================================
module cas_sequencer #(
   parameter int TRCD     = 4,
   parameter int TCCD     = 4,
   parameter int TWTR     = 2,
   parameter int CL       = 11,
   parameter int CWL      = 9,
   parameter int BG_WIDTH = 2,
   parameter int BA_WIDTH = 2,
   parameter int CA_WIDTH = 10
) (
   input  logic            clock_t,
   input  logic            reset_n,
   cas_sequencer_if.slave  bus
);

   localparam int c_aw      = BG_WIDTH + BA_WIDTH + CA_WIDTH;
   localparam int c_ww      = $clog2(TRCD + 1);
   localparam int c_gw      = $clog2(TCCD + TWTR + 1);
   localparam int c_lat_max = (CL > CWL) ? CL : CWL;
   localparam int c_depth   = c_lat_max + 1;

   localparam logic [c_ww-1:0] c_wait_miss = c_ww'(TRCD - 1);
   localparam logic [c_ww-1:0] c_wait_one  = c_ww'(1);
   localparam logic [c_gw-1:0] c_gap_norm  = c_gw'(TCCD - 1);
   localparam logic [c_gw-1:0] c_gap_wtr   = c_gw'(TCCD + TWTR - 1);
   localparam logic [c_gw-1:0] c_gap_one   = c_gw'(1);

   typedef struct packed {
      logic            rw;
      logic [c_aw-1:0] addr;
      logic [c_ww-1:0] wait_cnt;
   } entry_t;

   typedef enum logic [1:0] {
      CAS_IDLE  = 2'd0,
      CAS_WAIT  = 2'd1,
      CAS_ISSUE = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   entry_t [1:0]        r_fifo, w_fifo_nxt, w_dec;
   entry_t              w_new;
   logic [1:0]          r_cnt, w_cnt_nxt;
   logic [c_gw-1:0]     r_gap, w_gap_nxt;
   logic [c_gw-1:0]     r_wtr, w_wtr_nxt;
   logic [c_aw-1:0]     r_cas_reg;
   logic                r_cas_rw;
   logic                r_ovf;
   logic [c_depth-1:0]  r_pipe_vld, r_pipe_rw, w_pipe_vld, w_pipe_rw;
   logic                w_pop, w_push, w_drop, w_last_rw_nxt, w_elig;

   // Everything below looks one edge ahead: w_elig says whether the head
   // will be issuable in the cycle after this edge, so ISSUE needs no
   // extra qualifying cycle.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         w_dec[i] = r_fifo[i];
         if (r_fifo[i].wait_cnt != '0) begin
            w_dec[i].wait_cnt = r_fifo[i].wait_cnt - c_wait_one;
         end
      end

      w_new.rw       = bus.act_rw;
      w_new.addr     = {bus.act_bg, bus.act_ba, bus.act_col};
      w_new.wait_cnt = bus.act_hit ? '0 : c_wait_miss;

      w_pop  = (r_state == CAS_ISSUE);
      w_push = bus.act_rdy && ((r_cnt != 2'd2) || w_pop);
      w_drop = bus.act_rdy && !w_push;

      if (w_pop) begin
         w_fifo_nxt[0] = w_dec[1];
         w_fifo_nxt[1] = w_dec[1];
         w_cnt_nxt     = r_cnt - 2'd1;
      end else begin
         w_fifo_nxt = w_dec;
         w_cnt_nxt  = r_cnt;
      end
      if (w_push) begin
         if (w_cnt_nxt == 2'd0) begin
            w_fifo_nxt[0] = w_new;
         end else begin
            w_fifo_nxt[1] = w_new;
         end
         w_cnt_nxt = w_cnt_nxt + 2'd1;
      end

      w_last_rw_nxt = w_pop ? r_fifo[0].rw : r_cas_rw;
      w_gap_nxt     = (r_gap != '0) ? (r_gap - c_gap_one) : '0;
      w_wtr_nxt     = (r_wtr != '0) ? (r_wtr - c_gap_one) : '0;
      if (w_pop) begin
         w_gap_nxt = (!r_fifo[0].rw && (w_cnt_nxt != 2'd0) && w_fifo_nxt[0].rw)
                     ? c_gap_wtr : c_gap_norm;
         // Separate turnaround timer so a READ that arrives after the
         // WRITE has already left the queue is still held back.
         w_wtr_nxt = r_fifo[0].rw ? '0 : c_gap_wtr;
      end

      w_elig = (w_cnt_nxt != 2'd0) && (w_fifo_nxt[0].wait_cnt == '0) &&
               (w_gap_nxt == '0) &&
               !(w_fifo_nxt[0].rw && !w_last_rw_nxt && (w_wtr_nxt != '0));
   end

   always_ff @(posedge clock_t or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= CAS_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         CAS_IDLE:  if (w_push) w_state_nxt = w_elig ? CAS_ISSUE : CAS_WAIT;
         CAS_WAIT:  if (w_elig) w_state_nxt = CAS_ISSUE;
         CAS_ISSUE: w_state_nxt = w_elig ? CAS_ISSUE :
                                  ((w_cnt_nxt != 2'd0) ? CAS_WAIT : CAS_IDLE);
         default:   w_state_nxt = CAS_IDLE;
      endcase
   end

   // Issued bursts enter at their latency tap and shift toward tap 0 on the
   // same edge, so tap 0 is reached exactly CL/CWL cycles after the issue.
   always_comb begin
      w_pipe_vld = r_pipe_vld;
      w_pipe_rw  = r_pipe_rw;
      if (w_pop) begin
         if (r_fifo[0].rw) begin
            w_pipe_vld[CL] = 1'b1;
            w_pipe_rw[CL]  = 1'b1;
         end else begin
            w_pipe_vld[CWL] = 1'b1;
            w_pipe_rw[CWL]  = 1'b0;
         end
      end
   end

   always_ff @(posedge clock_t or negedge reset_n) begin
      if (!reset_n) begin
         r_fifo     <= '0;
         r_cnt      <= 2'd0;
         r_gap      <= '0;
         r_wtr      <= '0;
         r_cas_reg  <= '0;
         r_cas_rw   <= 1'b0;
         r_ovf      <= 1'b0;
         r_pipe_vld <= '0;
         r_pipe_rw  <= '0;
      end else begin
         r_fifo     <= w_fifo_nxt;
         r_cnt      <= w_cnt_nxt;
         r_gap      <= w_gap_nxt;
         r_wtr      <= w_wtr_nxt;
         r_pipe_vld <= w_pipe_vld >> 1;
         r_pipe_rw  <= w_pipe_rw >> 1;
         if (w_pop) begin
            r_cas_reg <= r_fifo[0].addr;
            r_cas_rw  <= r_fifo[0].rw;
         end
         if (w_drop) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign bus.cas_rdy  = w_pop;
   assign bus.cas_reg  = w_pop ? r_fifo[0].addr : r_cas_reg;
   assign bus.cas_rw   = w_pop ? r_fifo[0].rw : r_cas_rw;
   assign bus.cas_idle = (r_cnt == 2'd0) && !w_pop && (r_pipe_vld == '0);
   assign bus.data_rdy = r_pipe_vld[0];
   assign bus.data_rw  = r_pipe_rw[0];
   assign bus.overflow = r_ovf;

endmodule
`default_nettype wire
